srt4_div_ctrl: RTL

- Sequencing controller for the radix-4 SRT divider datapath.
- Accepts a start/done handshake from the host.
- Drives load enables for the 26-bit operand, partial-remainder and quotient registers, and counts iterations (2 quotient bits per iteration).
- Runs the final sign-correction step and flags divide-by-zero.
- Sits between the host interface and the divider datapath; it contains no arithmetic on the 26-bit data itself.

---
 rtl/srt4_div_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/srt4_div_ctrl.sv
// Sequencing FSM for the radix-4 SRT divider datapath.
// Drives operand/remainder/quotient load enables, iteration count and sign fix-up.
module srt4_div_ctrl #(
  parameter int ITER  = 13,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             divisor_zero,
  input  logic             rem_neg,
  output logic             load_op,
  output logic             load_rem,
  output logic             load_q,
  output logic             correct_en,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_CORR = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] ZERO = '0;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dbz;
  logic             w_dbz_nxt;
  logic             w_active;

  assign w_active = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= ZERO;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dbz   <= w_dbz_nxt;
    end
  end

  // abort outranks every other transition once an operation is in flight
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dbz_nxt   = r_dbz;
    if (abort && w_active) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = ZERO;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_cnt_nxt = ZERO;
          if (start && !abort) begin
            w_state_nxt = S_LOAD;
            w_dbz_nxt   = 1'b0;
          end
        end
        S_LOAD: begin
          w_cnt_nxt = ZERO;
          if (divisor_zero) begin
            w_state_nxt = S_DONE;
            w_dbz_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_ITER;
          end
        end
        S_ITER: begin
          if (r_cnt >= LAST) begin
            w_state_nxt = S_CORR;
            w_cnt_nxt   = LAST;
          end else begin
            w_cnt_nxt = r_cnt + ONE;
          end
        end
        S_CORR: begin
          w_state_nxt = S_DONE;
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = ZERO;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = ZERO;
        end
      endcase
    end
  end

  // Moore decode; only the fix-up step looks at the live remainder sign
  always_comb begin
    load_op    = 1'b0;
    load_rem   = 1'b0;
    load_q     = 1'b0;
    correct_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD: begin
        busy     = 1'b1;
        load_op  = 1'b1;
        load_rem = 1'b1;
        load_q   = 1'b1;
      end
      S_ITER: begin
        busy     = 1'b1;
        load_rem = 1'b1;
        load_q   = 1'b1;
      end
      S_CORR: begin
        busy       = 1'b1;
        correct_en = rem_neg;
        load_rem   = rem_neg;
        load_q     = rem_neg;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign div_by_zero = r_dbz;
  assign iter_cnt    = r_cnt;

endmodule
